mem_access_controller: RTL and testbench
========================================

Name: mem_access_controller

Overview:
- CPU-side initiator for the byte-addressed, big-endian memory unit's Enable/ReadWrite/wordSelector/MFC interface.
- Accepts one load/store request at a time from the datapath and sequences the memory handshake.
- Waits for MFC, with a cycle timeout, then returns load data zero- or sign-extended for ARM LDR/LDRB/LDRH/LDRSB/LDRSH and STR/STRB/STRH.
- Sits between the ARM datapath/control unit and memory_unit.

Parameters:
TIMEOUT, 16, max ACCESS-state cycles waiting for MFC before Error (>=1)
USE_MFC, 1, 1 = complete on sampled MFC; 0 = complete after FIXED_WAIT cycles, never times out
FIXED_WAIT, 2, ACCESS cycles used when USE_MFC=0 (>=1)
CHECK_ALIGN, 1, 1 = reject misaligned half/word requests without a memory access

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  reset, asynchronous, active-low
Start  in  1  request strobe, sampled only in IDLE
Rw  in  1  1 = read (load), 0 = write (store)
Size  in  2  00 byte, 01 halfword, 10 word, 11 treated as byte
Signed  in  1  sign-extend byte/half loads
AddrIn  in  32  byte address
StoreData  in  32  store data, right-justified
Busy  out  1  high from the cycle after accepted Start until Done
Done  out  1  one-cycle completion pulse
LoadData  out  32  extended load result, valid with Done, held until next Done
Error  out  1  timeout flag, valid with Done, held until next accepted Start
AlignErr  out  1  misalignment flag, valid with Done, held until next accepted Start
Enable  out  1  memory enable
ReadWrite  out  1  to memory, 1 = read
Address  out  32  to memory
DataIn  out  32  store data to memory
wordSelector  out  2  size code to memory
MemData  in  32  memory DataOut
MFC  in  1  memory function complete

Behaviour:
- Reset, asynchronous on Reset_n=0: state IDLE; all outputs 0, including Enable, Busy, Done, LoadData, Error, AlignErr, Address, DataIn, ReadWrite, wordSelector; wait counter 0. Takes effect immediately, including mid-access. No Done is generated for an aborted access.
- States: IDLE, SETUP, ACCESS, CAPTURE, DONE.
- IDLE:
  - Start=1 latches Rw, Size (11 becomes 00), Signed, AddrIn and StoreData, clears Error and AlignErr, and goes to SETUP.
  - If CHECK_ALIGN=1 and the request is misaligned (half with AddrIn[0]=1, word with AddrIn[1:0]!=0), it sets AlignErr and goes directly to DONE instead; Enable is never asserted.
- SETUP, one cycle: Address, ReadWrite, wordSelector and DataIn are driven stable; Enable=0.
- ACCESS:
  - Enable=1; the wait counter increments each cycle.
  - USE_MFC=1: MFC sampled 1 goes to CAPTURE. Counter reaching TIMEOUT with no MFC sets Error and goes to CAPTURE.
  - USE_MFC=0: goes to CAPTURE when the counter reaches FIXED_WAIT.
  - MFC outside ACCESS is ignored.
- CAPTURE:
  - Enable=0.
  - For reads without Error, latch MemData:
    - byte: MemData[7:0], extended.
    - half: MemData[15:0], extended.
    - word: MemData as-is.
    - Extension is sign if Signed=1, else zero.
  - Writes, or reads with Error, leave LoadData unchanged.
  - Go to DONE.
- DONE: Done=1 for exactly one cycle, then IDLE. Start is accepted again the cycle after DONE.
- Store lane mapping: byte uses DataIn[7:0]=StoreData[7:0], half uses [15:0], word uses [31:0]. Unused DataIn bits are 0.
- Busy = (state != IDLE).
- Start while Busy is ignored and not queued.
- Latency, aligned access: Start edge, then SETUP, ACCESS (n cycles), CAPTURE, DONE. Done is asserted n+3 cycles after the Start edge.
- Memory-side outputs hold their values after the access until the next request.

Decomposition:
- Shared package: size codes (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10), RW_READ=1, RW_WRITE=0, and the FSM state encoding. memory_unit uses the same size and RW constants.
- One sub-module, load_extender: combinational; takes MemData, Size and Signed, produces the 32-bit extended result. It is unit-tested separately.

Test Plan:
- Word read: memory holds 0x11,0x22,0x33,0x44 at address 0x10, Start Rw=1 Size=10, MFC after 2 cycles -> LoadData=0x11223344, one-cycle Done, Error=0, Busy dropped on the cycle after Done.
- Signed loads: byte 0x80, Signed=1 -> 0xFFFFFF80; Signed=0 -> 0x00000080. Half 0x8001 at address 0x20, Signed=1 -> 0xFFFF8001.
- Half store: StoreData=0xDEADBEEF, Size=01, AddrIn=0x40 -> Address=0x40, DataIn=0x0000BEEF, ReadWrite=0, Enable high only in ACCESS. Memory then holds 0xBE at 0x40 and 0xEF at 0x41.
- Timeout: MFC tied 0, TIMEOUT=16 -> Enable high exactly 16 cycles, Done with Error=1, LoadData unchanged.
- Misaligned word at AddrIn=0x41 -> AlignErr=1, Done 2 cycles after Start, Enable never asserted.
- Robustness: a second Start while Busy is ignored (exactly one Done). Reset_n=0 during ACCESS drives Enable and Busy to 0 immediately, and no Done follows.

Source files
------------

// File: rtl/mem_access_controller_pkg.sv
// Shared definitions for the memory access controller and the memory unit.
//   - size codes carried on wordSelector
//   - read/write encoding carried on ReadWrite
//   - controller FSM state encoding
//   - small helpers for size normalisation, alignment and store lane masking
package mem_access_controller_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // The reserved size code 11 behaves as a byte access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_BYTE : size;
    endfunction

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (size == SZ_HALF)
            bad = addr_lo[0];
        else if (size == SZ_WORD)
            bad = (addr_lo != 2'b00);
        return bad;
    endfunction

    // Store data is right-justified; bits above the access width go out as 0.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            SZ_HALF: lanes = {16'h0000, data[15:0]};
            SZ_WORD: lanes = data;
            default: lanes = {24'h000000, data[7:0]};
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_access_controller_load_extender.sv
// load_extender: combinational zero/sign extension of right-justified
// memory read data.
//   mem_data  in  32  memory DataOut, right-justified
//   size      in  2   size code (11 treated as byte)
//   sign      in  1   1 = sign-extend byte/half results
//   ext_data  out 32  extended load result
module load_extender
    import mem_access_controller_pkg::*;
(
    input  logic [31:0] mem_data,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] ext_data
);

    always_comb begin
        ext_data = {{24{sign & mem_data[7]}}, mem_data[7:0]};
        case (size)
            SZ_HALF: ext_data = {{16{sign & mem_data[15]}}, mem_data[15:0]};
            SZ_WORD: ext_data = mem_data;
            default: ext_data = {{24{sign & mem_data[7]}}, mem_data[7:0]};
        endcase
    end

endmodule

// File: rtl/mem_access_controller.sv
// mem_access_controller: CPU-side initiator for the big-endian memory unit.
// Accepts one load/store at a time, drives the Enable/ReadWrite/wordSelector
// handshake, waits for MFC (with a cycle timeout) or a fixed delay, and
// returns extended load data.
// Ports:
//   Clk, Reset_n                  clock, async active-low reset
//   Start, Rw, Size, Signed       request (sampled only when idle)
//   AddrIn, StoreData             request address / right-justified store data
//   Busy, Done                    status; Done is a one-cycle pulse
//   LoadData, Error, AlignErr     results, valid with Done
//   Enable, ReadWrite, Address,
//   DataIn, wordSelector          memory-side request
//   MemData, MFC                  memory-side response
module mem_access_controller
    import mem_access_controller_pkg::*;
#(
    parameter int TIMEOUT     = 16,
    parameter int USE_MFC     = 1,
    parameter int FIXED_WAIT  = 2,
    parameter int CHECK_ALIGN = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        Rw,
    input  logic [1:0]  Size,
    input  logic        Signed,
    input  logic [31:0] AddrIn,
    input  logic [31:0] StoreData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] LoadData,
    output logic        Error,
    output logic        AlignErr,
    output logic        Enable,
    output logic        ReadWrite,
    output logic [31:0] Address,
    output logic [31:0] DataIn,
    output logic [1:0]  wordSelector,
    input  logic [31:0] MemData,
    input  logic        MFC
);

    localparam int CNT_MAX = (TIMEOUT > FIXED_WAIT) ? TIMEOUT : FIXED_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [CNT_W-1:0]   cnt_inc;
    logic               timeout_hit;

    logic               rw_reg;
    logic [1:0]         size_reg;
    logic               sign_reg;
    logic [31:0]        load_reg;
    logic               error_reg;
    logic               align_reg;
    logic               mem_rw_reg;
    logic [31:0]        mem_addr_reg;
    logic [31:0]        mem_din_reg;
    logic [1:0]         mem_ws_reg;

    logic [1:0]         req_size;
    logic               req_bad;
    logic [31:0]        ext_data;

    assign req_size = norm_size(Size);
    assign req_bad  = (CHECK_ALIGN != 0) && is_misaligned(req_size, AddrIn[1:0]);
    assign cnt_inc  = cnt_reg + CNT_W'(1);

    load_extender u_load_extender (
        .mem_data (MemData),
        .size     (size_reg),
        .sign     (sign_reg),
        .ext_data (ext_data)
    );

    // Next-state logic. The counter value after this ACCESS cycle (cnt_inc)
    // is what gets compared, so ACCESS lasts exactly TIMEOUT / FIXED_WAIT
    // cycles when it runs to the limit.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        timeout_hit = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (Start)
                    state_next = req_bad ? ST_DONE : ST_SETUP;
            end
            ST_SETUP: begin
                cnt_next   = '0;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                cnt_next = cnt_inc;
                if (USE_MFC != 0) begin
                    if (MFC) begin
                        state_next = ST_CAPTURE;
                    end else if (cnt_inc >= CNT_W'(TIMEOUT)) begin
                        timeout_hit = 1'b1;
                        state_next  = ST_CAPTURE;
                    end
                end else if (cnt_inc >= CNT_W'(FIXED_WAIT)) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Request latch, memory-side registers and result registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rw_reg       <= 1'b0;
            size_reg     <= SZ_BYTE;
            sign_reg     <= 1'b0;
            load_reg     <= '0;
            error_reg    <= 1'b0;
            align_reg    <= 1'b0;
            mem_rw_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_din_reg  <= '0;
            mem_ws_reg   <= 2'b00;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (Start) begin
                        rw_reg    <= Rw;
                        size_reg  <= req_size;
                        sign_reg  <= Signed;
                        error_reg <= 1'b0;
                        align_reg <= req_bad;
                        // A rejected request never reaches memory, so the
                        // memory side keeps showing the previous access.
                        if (!req_bad) begin
                            mem_rw_reg   <= Rw;
                            mem_addr_reg <= AddrIn;
                            mem_din_reg  <= store_lanes(req_size, StoreData);
                            mem_ws_reg   <= req_size;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (timeout_hit)
                        error_reg <= 1'b1;
                end
                ST_CAPTURE: begin
                    if ((rw_reg == RW_READ) && !error_reg)
                        load_reg <= ext_data;
                end
                default: ;
            endcase
        end
    end

    assign Busy         = (state_reg != ST_IDLE);
    assign Done         = (state_reg == ST_DONE);
    assign Enable       = (state_reg == ST_ACCESS);
    assign LoadData     = load_reg;
    assign Error        = error_reg;
    assign AlignErr     = align_reg;
    assign ReadWrite    = mem_rw_reg;
    assign Address      = mem_addr_reg;
    assign DataIn       = mem_din_reg;
    assign wordSelector = mem_ws_reg;

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench for mem_access_controller with a behavioural big-endian
// memory that raises MFC after a per-vector number of Enable cycles.
module tb_mem_access_controller;

    localparam int TIMEOUT = 16;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic        Rw;
    logic [1:0]  Size;
    logic        Signed;
    logic [31:0] AddrIn;
    logic [31:0] StoreData;
    logic        Busy;
    logic        Done;
    logic [31:0] LoadData;
    logic        Error;
    logic        AlignErr;
    logic        Enable;
    logic        ReadWrite;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [1:0]  wordSelector;
    logic [31:0] MemData;
    logic        MFC;

    mem_access_controller #(
        .TIMEOUT     (TIMEOUT),
        .USE_MFC     (1),
        .FIXED_WAIT  (2),
        .CHECK_ALIGN (1)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .Rw           (Rw),
        .Size         (Size),
        .Signed       (Signed),
        .AddrIn       (AddrIn),
        .StoreData    (StoreData),
        .Busy         (Busy),
        .Done         (Done),
        .LoadData     (LoadData),
        .Error        (Error),
        .AlignErr     (AlignErr),
        .Enable       (Enable),
        .ReadWrite    (ReadWrite),
        .Address      (Address),
        .DataIn       (DataIn),
        .wordSelector (wordSelector),
        .MemData      (MemData),
        .MFC          (MFC)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- memory model ----------------
    logic [7:0] mem [0:255];
    logic       mem_init;
    int         mfc_at;     // Enable cycle in which MFC is seen; 0 = never
    int         mem_cnt;

    always @(posedge Clk) begin
        logic [7:0] a;
        a = Address[7:0];
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h10] <= 8'h11; mem[8'h11] <= 8'h22;
            mem[8'h12] <= 8'h33; mem[8'h13] <= 8'h44;
            mem[8'h20] <= 8'h80; mem[8'h21] <= 8'h01;
            mem[8'h22] <= 8'h7F; mem[8'h23] <= 8'hFE;
            MFC     <= 1'b0;
            MemData <= '0;
            mem_cnt <= 0;
        end else if (Enable) begin
            if (mfc_at >= 2 && mem_cnt == mfc_at - 2) begin
                MFC <= 1'b1;
                case (wordSelector)
                    2'b01:   MemData <= {16'h0, mem[a], mem[a + 8'd1]};
                    2'b10:   MemData <= {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
                    default: MemData <= {24'h0, mem[a]};
                endcase
                if (!ReadWrite) begin
                    case (wordSelector)
                        2'b01: begin
                            mem[a]        <= DataIn[15:8];
                            mem[a + 8'd1] <= DataIn[7:0];
                        end
                        2'b10: begin
                            mem[a]        <= DataIn[31:24];
                            mem[a + 8'd1] <= DataIn[23:16];
                            mem[a + 8'd2] <= DataIn[15:8];
                            mem[a + 8'd3] <= DataIn[7:0];
                        end
                        default: mem[a] <= DataIn[7:0];
                    endcase
                end
            end
            mem_cnt <= mem_cnt + 1;
        end else begin
            MFC     <= 1'b0;
            mem_cnt <= 0;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", nm, act);
        end
    endtask

    typedef struct {
        logic        rw;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] sdata;
        int          n_acc;      // Enable cycles until MFC is sampled; 0 = never
        logic        keep;       // LoadData expected unchanged
        logic [31:0] exp_load;
        logic        exp_err;
        logic        exp_align;
        logic [31:0] exp_din;
        logic [1:0]  exp_ws;
    } vec_t;

    typedef struct {
        logic [31:0] load;
        logic        err;
        logic        align;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_load = '0;

    task automatic run_vec(input int idx, input vec_t v);
        exp_t        e;
        exp_t        g;
        int          lat;
        int          en_cycles;
        int          exp_en;
        logic        got;
        logic        seen;
        logic [31:0] a_addr;
        logic [31:0] a_din;
        logic        a_rw;
        logic [1:0]  a_ws;

        e.load    = v.keep ? last_load : v.exp_load;
        e.err     = v.exp_err;
        e.align   = v.exp_align;
        last_load = e.load;
        sb.push_back(e);
        exp_en = v.exp_align ? 0 : ((v.n_acc == 0) ? TIMEOUT : v.n_acc);

        mfc_at = v.n_acc;
        @(negedge Clk);
        Rw = v.rw; Size = v.size; Signed = v.sgn; AddrIn = v.addr; StoreData = v.sdata;
        Start = 1'b1;
        @(posedge Clk);
        lat = 0; en_cycles = 0; got = 1'b0; seen = 1'b0;
        a_addr = '0; a_din = '0; a_rw = 1'b0; a_ws = 2'b00;
        while (!got && lat < 100) begin
            lat++;
            @(negedge Clk);
            Start = 1'b0;
            if (lat == 1) chk($sformatf("v%0d busy_after_start", idx), Busy, 1);
            if (Enable) begin
                if (!seen) begin
                    a_addr = Address; a_din = DataIn; a_rw = ReadWrite; a_ws = wordSelector;
                end
                seen = 1'b1;
                en_cycles++;
            end
            if (Done) got = 1'b1;
            else @(posedge Clk);
        end
        chk($sformatf("v%0d done_seen", idx), got, 1);
        if (got) begin
            g = sb.pop_front();
            chk($sformatf("v%0d load_data", idx), LoadData, g.load);
            chk($sformatf("v%0d error", idx), Error, g.err);
            chk($sformatf("v%0d align_err", idx), AlignErr, g.align);
        end
        chk($sformatf("v%0d enable_cycles", idx), en_cycles, exp_en);
        if (v.exp_align)
            chk($sformatf("v%0d align_latency_le2", idx), (lat <= 2), 1);
        else
            chk($sformatf("v%0d latency", idx), lat, exp_en + 3);
        if (seen) begin
            chk($sformatf("v%0d mem_address", idx), a_addr, v.addr);
            chk($sformatf("v%0d mem_datain", idx), a_din, v.exp_din);
            chk($sformatf("v%0d mem_readwrite", idx), a_rw, v.rw);
            chk($sformatf("v%0d mem_wordsel", idx), a_ws, v.exp_ws);
        end
        @(negedge Clk);
        chk($sformatf("v%0d done_one_cycle", idx), Done, 0);
        chk($sformatf("v%0d busy_dropped", idx), Busy, 0);
    endtask

    vec_t vecs[17];

    initial begin
        int dones;
        logic got_en;

        //            rw    size   sgn   addr        sdata          n  keep exp_load       err   align din            ws
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h0,          2, 1'b0, 32'h11223344, 1'b0, 1'b0, 32'h0,         2'b10};
        vecs[1]  = '{1'b1, 2'b00, 1'b1, 32'h20, 32'h0,          3, 1'b0, 32'hFFFFFF80, 1'b0, 1'b0, 32'h0,         2'b00};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h20, 32'h0,          2, 1'b0, 32'h00000080, 1'b0, 1'b0, 32'h0,         2'b00};
        vecs[3]  = '{1'b1, 2'b01, 1'b1, 32'h20, 32'h0,          4, 1'b0, 32'hFFFF8001, 1'b0, 1'b0, 32'h0,         2'b01};
        vecs[4]  = '{1'b1, 2'b01, 1'b0, 32'h20, 32'h0,          2, 1'b0, 32'h00008001, 1'b0, 1'b0, 32'h0,         2'b01};
        vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h40, 32'hDEADBEEF,   2, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0000BEEF,  2'b01};
        vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h40, 32'h0,          2, 1'b0, 32'h000000BE, 1'b0, 1'b0, 32'h0,         2'b00};
        vecs[7]  = '{1'b1, 2'b00, 1'b1, 32'h41, 32'h0,          2, 1'b0, 32'hFFFFFFEF, 1'b0, 1'b0, 32'h0,         2'b00};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h50, 32'hCAFEF00D,   3, 1'b1, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D,  2'b10};
        vecs[9]  = '{1'b1, 2'b10, 1'b1, 32'h50, 32'h0,          2, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0,         2'b10};
        vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h60, 32'h12345678,   2, 1'b1, 32'h0,        1'b0, 1'b0, 32'h00000078,  2'b00};
        vecs[11] = '{1'b1, 2'b11, 1'b1, 32'h60, 32'h0,          2, 1'b0, 32'h00000078, 1'b0, 1'b0, 32'h0,         2'b00};
        vecs[12] = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h0,          0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,         2'b10};
        vecs[13] = '{1'b1, 2'b10, 1'b0, 32'h41, 32'h0,          2, 1'b1, 32'h0,        1'b0, 1'b1, 32'h0,         2'b10};
        vecs[14] = '{1'b1, 2'b01, 1'b1, 32'h21, 32'h0,          2, 1'b1, 32'h0,        1'b0, 1'b1, 32'h0,         2'b01};
        vecs[15] = '{1'b0, 2'b01, 1'b0, 32'h43, 32'h1234,       2, 1'b1, 32'h0,        1'b0, 1'b1, 32'h0,         2'b01};
        vecs[16] = '{1'b1, 2'b01, 1'b1, 32'h22, 32'h0,          5, 1'b0, 32'h00007FFE, 1'b0, 1'b0, 32'h0,         2'b01};

        Reset_n = 1'b0; mem_init = 1'b1; mfc_at = 0;
        Start = 1'b0; Rw = 1'b0; Size = 2'b00; Signed = 1'b0; AddrIn = '0; StoreData = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst busy", Busy, 0);
        chk("rst done", Done, 0);
        chk("rst enable", Enable, 0);
        chk("rst loaddata", LoadData, 0);
        chk("rst error", Error, 0);
        chk("rst alignerr", AlignErr, 0);
        chk("rst address", Address, 0);
        chk("rst datain", DataIn, 0);
        chk("rst readwrite", ReadWrite, 0);
        chk("rst wordsel", wordSelector, 0);
        mem_init = 1'b0;
        Reset_n  = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

        // Start while busy: the second request must be dropped, one Done only.
        mfc_at = 4;
        @(negedge Clk);
        Rw = 1'b1; Size = 2'b10; Signed = 1'b0; AddrIn = 32'h10; StoreData = '0; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        Rw = 1'b1; Size = 2'b00; Signed = 1'b1; AddrIn = 32'h20; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        dones = 0;
        repeat (30) begin
            @(negedge Clk);
            if (Done) dones++;
        end
        chk("busy_start dones", dones, 1);
        chk("busy_start loaddata", LoadData, 32'h11223344);
        chk("busy_start idle", Busy, 0);

        // Reset during ACCESS: immediate drop of Enable/Busy, no Done afterwards.
        mfc_at = 0;
        @(negedge Clk);
        Rw = 1'b1; Size = 2'b10; AddrIn = 32'h10; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        got_en = 1'b0;
        for (int k = 0; k < 10 && !got_en; k++) begin
            @(negedge Clk);
            if (Enable) got_en = 1'b1;
        end
        chk("rst_mid enable_reached", got_en, 1);
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_mid enable", Enable, 0);
        chk("rst_mid busy", Busy, 0);
        chk("rst_mid loaddata", LoadData, 0);
        chk("rst_mid address", Address, 0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        dones = 0;
        repeat (25) begin
            @(negedge Clk);
            if (Done) dones++;
        end
        chk("rst_mid no_done", dones, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
